// File: rtl/mill_modif_enc.sv
// Modified Miller encoder for the reader-to-card link at 106 kb/s.
// NRZ-L bits arrive over a valid/ready handshake. Each bit is encoded as one
// ETU-long symbol (X, Y or Z) on out_pause. SOC and EOC framing is added
// around the data bits automatically.
module mill_modif_enc #(
  parameter int ETU_CLKS   = 32,
  parameter int PAUSE_CLKS = 8,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic in_PoR,
  input  logic in_start,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_last,
  output logic out_ready,
  output logic out_pause,
  output logic out_busy,
  output logic out_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOC  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOC0 = 3'd3,
    ST_EOCY = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SYM_X = 2'd0,
    SYM_Y = 2'd1,
    SYM_Z = 2'd2
  } sym_t;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ETU_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF    = CNT_W'(ETU_CLKS / 2);
  localparam logic [CNT_W-1:0] CNT_X_END   = CNT_W'(ETU_CLKS / 2 + PAUSE_CLKS);
  localparam logic [CNT_W-1:0] CNT_Z_END   = CNT_W'(PAUSE_CLKS);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // A logic 1 is always X; a logic 0 is Y after a 1 and Z after a 0.
  function automatic sym_t map_sym(input logic bit_v, input logic prev_v);
    sym_t s;
    if (bit_v) begin
      s = SYM_X;
    end else if (prev_v) begin
      s = SYM_Y;
    end else begin
      s = SYM_Z;
    end
    return s;
  endfunction

  // Pause window of a symbol at a given position inside its ETU.
  function automatic logic pause_of(input sym_t s, input logic [CNT_W-1:0] c);
    logic p;
    case (s)
      SYM_X:   p = (c >= CNT_HALF) && (c < CNT_X_END);
      SYM_Z:   p = (c < CNT_Z_END);
      SYM_Y:   p = 1'b0;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  state_t           state_r, state_s;
  sym_t             sym_r, sym_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             prev_r, prev_s;
  logic             last_acc_r, last_acc_s;
  logic             ready_r, ready_s;
  logic             pause_r, pause_s;
  logic             busy_r, busy_s;
  logic             underrun_r, underrun_s;
  logic             wrap_s;

  // Next-state, symbol selection and handshake decode for the frame FSM.
  always_comb begin
    state_s    = state_r;
    sym_s      = sym_r;
    cnt_s      = cnt_r;
    prev_s     = prev_r;
    last_acc_s = last_acc_r;
    underrun_s = 1'b0;
    wrap_s     = (cnt_r == CNT_LAST);

    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (in_start) begin
          // SOC is a Z and leaves the encoder as if a 0 had been sent.
          state_s    = ST_SOC;
          sym_s      = SYM_Z;
          prev_s     = 1'b0;
          last_acc_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SOC, ST_DATA: begin
        cnt_s = wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        if (wrap_s) begin
          if (last_acc_r) begin
            // Final bit has been sent: EOC starts with a logic 0.
            state_s = ST_EOC0;
            sym_s   = map_sym(1'b0, prev_r);
            prev_s  = 1'b0;
          end else if (in_valid) begin
            state_s    = ST_DATA;
            sym_s      = map_sym(in_bit, prev_r);
            prev_s     = in_bit;
            last_acc_s = in_last;
          end else begin
            // Nothing offered when a bit was due: close the frame cleanly.
            underrun_s = 1'b1;
            state_s    = ST_EOC0;
            sym_s      = map_sym(1'b0, prev_r);
            prev_s     = 1'b0;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_EOC0: begin
        cnt_s = wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        if (wrap_s) begin
          state_s = ST_EOCY;
          sym_s   = SYM_Y;
        end else begin
          state_s = ST_EOC0;
        end
      end
      ST_EOCY: begin
        cnt_s = wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        if (wrap_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_EOCY;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    // Outputs are registered, so they are decoded from the next-cycle values.
    ready_s = (cnt_s == CNT_LAST) && !last_acc_s &&
              ((state_s == ST_SOC) || (state_s == ST_DATA));
    busy_s  = (state_s != ST_IDLE);
    // One clock of latency from the decoded count to the pause output.
    pause_s = (state_r != ST_IDLE) && pause_of(sym_r, cnt_r);
  end

  // State, counter and registered outputs; reset drops the pause at once.
  always_ff @(posedge clk or negedge in_PoR) begin
    if (!in_PoR) begin
      state_r    <= ST_IDLE;
      sym_r      <= SYM_Y;
      cnt_r      <= CNT_ZERO;
      prev_r     <= 1'b0;
      last_acc_r <= 1'b0;
      ready_r    <= 1'b0;
      pause_r    <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      sym_r      <= sym_s;
      cnt_r      <= cnt_s;
      prev_r     <= prev_s;
      last_acc_r <= last_acc_s;
      ready_r    <= ready_s;
      pause_r    <= pause_s;
      busy_r     <= busy_s;
      underrun_r <= underrun_s;
    end
  end

  assign out_ready    = ready_r;
  assign out_pause    = pause_r;
  assign out_busy     = busy_r;
  assign out_underrun = underrun_r;

endmodule

// File: tb/tb_mill_modif_enc.sv
// Scoreboard bench for the modified Miller encoder. Stimulus pushes expected
// pause offsets (relative to the first busy cycle) and per-frame summaries;
// a monitor pops and compares them as the DUT produces pauses and frames.
module tb_mill_modif_enc;

  logic clk = 1'b0;
  logic in_PoR = 1'b0;
  logic in_start = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_last = 1'b0;
  logic out_ready, out_pause, out_busy, out_underrun;

  typedef struct {
    int len;
    int rdy;
    int und;
    int np;
  } frm_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_pause_q[$];
  frm_t exp_frm_q[$];
  logic [1:0] feed_q[$];   // {last, bit}
  logic tog_en = 1'b0;

  mill_modif_enc dut (
    .clk          (clk),
    .in_PoR       (in_PoR),
    .in_start     (in_start),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .in_last      (in_last),
    .out_ready    (out_ready),
    .out_pause    (out_pause),
    .out_busy     (out_busy),
    .out_underrun (out_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bit driver: presents the next queued bit only while out_ready is high.
  initial begin
    forever begin
      @(negedge clk);
      if (tog_en) begin
        in_valid = 1'($urandom_range(0, 1));
        in_bit   = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
      end else if (out_ready && in_PoR && feed_q.size() > 0) begin
        logic [1:0] e;
        e = feed_q.pop_front();
        in_valid = 1'b1;
        in_bit   = e[0];
        in_last  = e[1];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
      end
    end
  end

  // Monitor: measures pauses and frame summaries and checks them against the queues.
  initial begin
    int cyc = 0, t0 = 0, p_start = 0;
    int rdy_n = 0, und_n = 0, pause_n = 0;
    logic in_frame = 1'b0, p_on = 1'b0, prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!in_PoR) begin
        in_frame  = 1'b0;
        p_on      = 1'b0;
        prev_busy = 1'b0;
      end else begin
        cyc++;
        if (out_busy && !prev_busy) begin
          in_frame = 1'b1;
          t0 = cyc;
          rdy_n = 0;
          und_n = 0;
          pause_n = 0;
        end
        if (in_frame) begin
          if (out_ready) rdy_n++;
          if (out_underrun) und_n++;
          if (out_pause && !p_on) begin
            p_on = 1'b1;
            p_start = cyc;
            pause_n++;
            if (exp_pause_q.size() == 0) begin
              chk("unexpected_pause", cyc - t0, -1);
            end else begin
              chk("pause_offset", cyc - t0, exp_pause_q.pop_front());
            end
          end else if (!out_pause && p_on) begin
            p_on = 1'b0;
            chk("pause_length", cyc - p_start, 8);
          end
        end
        if (!out_busy && prev_busy && in_frame) begin
          in_frame = 1'b0;
          if (exp_frm_q.size() == 0) begin
            chk("unexpected_frame", cyc - t0, -1);
          end else begin
            frm_t f;
            f = exp_frm_q.pop_front();
            chk("busy_length", cyc - t0, f.len);
            chk("ready_count", rdy_n, f.rdy);
            chk("underrun_count", und_n, f.und);
            chk("pause_count", pause_n, f.np);
          end
        end
        prev_busy = out_busy;
      end
    end
  end

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int i;
    i = 0;
    while (out_busy !== lvl && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (out_busy !== lvl) chk(name, 0, 1);
  endtask

  // Called at a negedge: raise in_start for exactly one sampling edge.
  task automatic pulse_start();
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic push_frame(input int len, input int rdy, input int und, input int np);
    frm_t f;
    f.len = len; f.rdy = rdy; f.und = und; f.np = np;
    exp_frm_q.push_back(f);
  endtask

  // Directed stimulus.
  initial begin
    // Reset held with toggling inputs: every output stays low.
    tog_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_start = 1'($urandom_range(0, 1));
      #1;
      chk("reset_outputs", {out_pause, out_busy, out_ready, out_underrun}, 0);
    end
    tog_en = 1'b0;
    in_start = 1'b0;
    @(negedge clk);
    in_PoR = 1'b1;
    repeat (3) @(negedge clk);

    // Frame A: 1,0,0(last) -> Z X Y Z Z Y. Stray in_start mid-frame.
    feed_q.push_back(2'b01); feed_q.push_back(2'b00); feed_q.push_back(2'b10);
    exp_pause_q.push_back(1);  exp_pause_q.push_back(49);
    exp_pause_q.push_back(97); exp_pause_q.push_back(129);
    push_frame(192, 3, 0, 4);
    // Frame B (back to back): 1(last) -> Z X Y Y.
    exp_pause_q.push_back(1); exp_pause_q.push_back(49);
    push_frame(128, 1, 0, 2);
    pulse_start();
    wait_busy(1'b1, 10, "start_a_timeout");
    repeat (50) @(negedge clk);
    pulse_start();
    wait_busy(1'b0, 400, "end_a_timeout");
    feed_q.push_back(2'b11);
    pulse_start();
    chk("no_gap_busy", 32'(out_busy), 1);
    wait_busy(1'b0, 400, "end_b_timeout");
    repeat (5) @(negedge clk);

    // Frame C: 0,1 then underrun -> Z Z X Y Y.
    feed_q.push_back(2'b00); feed_q.push_back(2'b01);
    exp_pause_q.push_back(1); exp_pause_q.push_back(33); exp_pause_q.push_back(81);
    push_frame(160, 3, 1, 3);
    pulse_start();
    wait_busy(1'b1, 10, "start_c_timeout");
    wait_busy(1'b0, 400, "end_c_timeout");
    repeat (5) @(negedge clk);

    // Frame D: reset in the middle of the SOC pause.
    feed_q.push_back(2'b01);
    exp_pause_q.push_back(1);
    pulse_start();
    wait_busy(1'b1, 10, "start_d_timeout");
    repeat (3) @(negedge clk);
    chk("pause_before_reset", 32'(out_pause), 1);
    #2;
    in_PoR = 1'b0;
    #1;
    chk("pause_dropped_at_reset", 32'(out_pause), 0);
    chk("busy_dropped_at_reset", 32'(out_busy), 0);
    feed_q.delete();
    repeat (3) @(negedge clk);
    in_PoR = 1'b1;
    repeat (2) @(negedge clk);

    // Frame E: 0(last) from a clean SOC -> Z Z Z Y (prev restarted at 0).
    feed_q.push_back(2'b10);
    exp_pause_q.push_back(1); exp_pause_q.push_back(33); exp_pause_q.push_back(65);
    push_frame(128, 1, 0, 3);
    pulse_start();
    wait_busy(1'b1, 10, "start_e_timeout");
    wait_busy(1'b0, 400, "end_e_timeout");
    repeat (5) @(negedge clk);

    chk("pauses_left", exp_pause_q.size(), 0);
    chk("frames_left", exp_frm_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
